// File: rtl/adder_feed_stage.sv
// Registered valid/ready wrapper around a combinational CLA adder: issue register feeding the
// adder, 2-entry result buffer with overflow/zero flags. Optional accumulate mode: ADDER_FEED_ACC_EN.
module adder_feed_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef ADDER_FEED_ACC_EN
    input  logic             in_acc,
`endif
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_f,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    logic             issue_vld_reg;
    logic [WIDTH-1:0] add_a_reg;
    logic [WIDTH-1:0] add_b_reg;
    logic             add_cin_reg;

    logic [WIDTH-1:0] sum_mem_reg  [2];
    logic             cout_mem_reg [2];
    logic             ovf_mem_reg  [2];
    logic             zero_mem_reg [2];
    logic             rd_ptr_reg;
    logic             wr_ptr_reg;
    logic [1:0]       cnt_reg;
    logic [1:0]       cnt_next;

    logic             in_fire;
    logic             out_fire;
    logic             cap_fire;
    logic             cap_ovf;
    logic             cap_zero;
    logic [WIDTH-1:0] b_next;

    assign out_valid = (cnt_reg != 2'd0);
    assign out_fire  = out_valid & out_ready;
    // A full buffer can still take the issue beat when the head leaves this cycle.
    assign cap_fire  = issue_vld_reg & ((cnt_reg < 2'd2) | out_fire);
    assign in_ready  = ~issue_vld_reg | cap_fire;
    assign in_fire   = in_valid & in_ready;

    assign cap_ovf  = (add_a_reg[WIDTH-1] == add_b_reg[WIDTH-1]) &
                      (add_f[WIDTH-1] != add_a_reg[WIDTH-1]);
    assign cap_zero = ~|add_f;

`ifdef ADDER_FEED_ACC_EN
    logic [WIDTH-1:0] acc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (cap_fire) begin
            acc_reg <= add_f;
        end
    end

    // Forward the result being captured so back-to-back accumulates see the newest sum.
    always_comb begin
        b_next = in_b;
        if (in_acc) begin
            b_next = cap_fire ? add_f : acc_reg;
        end
    end
`else
    assign b_next = in_b;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_vld_reg <= 1'b0;
            add_a_reg     <= '0;
            add_b_reg     <= '0;
            add_cin_reg   <= 1'b0;
        end else begin
            if (in_fire) begin
                issue_vld_reg <= 1'b1;
                add_a_reg     <= in_a;
                add_b_reg     <= b_next;
                add_cin_reg   <= in_cin;
            end else if (cap_fire) begin
                issue_vld_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        cnt_next = cnt_reg;
        case ({cap_fire, out_fire})
            2'b10:   cnt_next = cnt_reg + 2'd1;
            2'b01:   cnt_next = cnt_reg - 2'd1;
            default: cnt_next = cnt_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            cnt_reg    <= 2'd0;
        end else begin
            if (cap_fire) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (out_fire) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            cnt_reg <= cnt_next;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (rst) begin
                sum_mem_reg[gi]  <= '0;
                cout_mem_reg[gi] <= 1'b0;
                ovf_mem_reg[gi]  <= 1'b0;
                zero_mem_reg[gi] <= 1'b0;
            end else if (cap_fire && (wr_ptr_reg == 1'(gi))) begin
                sum_mem_reg[gi]  <= add_f;
                cout_mem_reg[gi] <= add_cout;
                ovf_mem_reg[gi]  <= cap_ovf;
                zero_mem_reg[gi] <= cap_zero;
            end
        end
    end

    assign add_a    = add_a_reg;
    assign add_b    = add_b_reg;
    assign add_cin  = add_cin_reg;
    assign out_sum  = sum_mem_reg[rd_ptr_reg];
    assign out_cout = cout_mem_reg[rd_ptr_reg];
    assign out_ovf  = ovf_mem_reg[rd_ptr_reg];
    assign out_zero = zero_mem_reg[rd_ptr_reg];

endmodule

// File: tb/tb_adder_feed_stage.sv
// Bench for adder_feed_stage: directed flag cases, backpressure, full-rate random stream,
// mid-stream reset and (with ADDER_FEED_ACC_EN) back-to-back accumulation, against a queue model.
module tb_adder_feed_stage;
    localparam int WIDTH = 32;
    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
    } res_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
`ifdef ADDER_FEED_ACC_EN
    logic             in_acc;
`endif
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_f;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    int               errors;
    int               checks;
    res_t             exp_q[$];
    logic [WIDTH-1:0] acc_model;
    bit               took;
    bit               got;
    res_t             obs;
    logic [WIDTH-1:0] seen_sums [8];
    int               n_seen;

    adder_feed_stage #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef ADDER_FEED_ACC_EN
        .in_acc    (in_acc),
`endif
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_f     (add_f),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    // Stand-in for the attached combinational CLA adder.
    assign {add_cout, add_f} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic res_t ref_add(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic cin);
        res_t   r;
        longint u;
        longint s;
        u = longint'(a) + longint'(b) + longint'(cin);
        s = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        r.sum  = u[WIDTH-1:0];
        r.cout = u[WIDTH];
        r.ovf  = (s > SMAX) || (s < SMIN);
        r.zero = (r.sum == '0);
        return r;
    endfunction

    task automatic check(string tag, logic [63:0] observed, logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock: sample handshakes just after the negedge drive, update the model, advance.
    task automatic step();
        logic [WIDTH-1:0] bsel;
        res_t             e;
        #1;
        took = in_valid && in_ready;
        got  = 1'b0;
        if (out_valid && out_ready) begin
            check("result_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                obs = {out_sum, out_cout, out_ovf, out_zero};
                got = 1'b1;
                check("result", 64'(obs), 64'(e));
                $display("out sum=%08h cout=%0b ovf=%0b zero=%0b", out_sum, out_cout, out_ovf, out_zero);
            end
        end
        if (took) begin
            bsel = in_b;
`ifdef ADDER_FEED_ACC_EN
            if (in_acc) bsel = acc_model;
`endif
            e = ref_add(in_a, bsel, in_cin);
            exp_q.push_back(e);
            acc_model = e.sum;
            $display("in  a=%08h b=%08h cin=%0b", in_a, bsel, in_cin);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic directed(string tag, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic cin,
                            res_t expected);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_lat0"}, 64'(out_valid), 64'd0);
        step();
        check({tag, "_lat1"}, 64'(out_valid), 64'd1);
        step();
        check({tag, "_got"}, 64'(got), 64'd1);
        check({tag, "_flags"}, 64'(obs), 64'(expected));
    endtask

    task automatic drain(string tag, int budget);
        int c;
        c = 0;
        while ((in_valid || exp_q.size() != 0) && c < budget) begin
            step();
            if (took) in_valid = 1'b0;
            if (got && n_seen < 8) begin
                seen_sums[n_seen] = obs.sum;
                n_seen++;
            end
            c++;
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        acc_model = '0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
`ifdef ADDER_FEED_ACC_EN
        in_acc    = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_sum", 64'(out_sum), 64'd0);
        check("reset_add_a", 64'(add_a), 64'd0);

        directed("ovf_pos", 32'h7FFFFFFF, 32'h1, 1'b0, '{32'h80000000, 1'b0, 1'b1, 1'b0});
        directed("ovf_neg", 32'h80000000, 32'hFFFFFFFF, 1'b0, '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0});
        directed("mixed", 32'd100, 32'hFFFFFFCE, 1'b0, '{32'd50, 1'b1, 1'b0, 1'b0});
        directed("zero", 32'd0, 32'd0, 1'b0, '{32'd0, 1'b0, 1'b0, 1'b1});
        directed("cin_wrap", 32'hFFFFFFFF, 32'd0, 1'b1, '{32'd0, 1'b1, 1'b0, 1'b1});

        // Backpressure: four beats against a stalled consumer.
        begin
            logic [WIDTH-1:0] bp_a [4];
            logic [WIDTH-1:0] bp_b [4];
            logic             bp_c [4];
            logic             bp_rdy [4];
            logic [WIDTH-1:0] bp_exp [4];
            bp_a = '{32'd10, 32'd50, -32'sd30, -32'sd10};
            bp_b = '{32'd15, 32'd30, -32'sd20, -32'sd5};
            bp_c = '{1'b1, 1'b0, 1'b0, 1'b1};
            bp_rdy = '{1'b1, 1'b1, 1'b1, 1'b0};
            bp_exp = '{32'd26, 32'd80, -32'sd50, -32'sd14};
            out_ready = 1'b0;
            for (int i = 0; i < 4; i++) begin
                in_valid = 1'b1;
                in_a     = bp_a[i];
                in_b     = bp_b[i];
                in_cin   = bp_c[i];
                check($sformatf("bp_in_ready%0d", i), 64'(in_ready), 64'(bp_rdy[i]));
                step();
            end
            check("bp_stall_ready", 64'(in_ready), 64'd0);
            check("bp_stall_valid", 64'(out_valid), 64'd1);
            out_ready = 1'b1;
            n_seen    = 0;
            drain("bp", 20);
            check("bp_count", 64'(n_seen), 64'd4);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("bp_sum%0d", i), 64'(seen_sums[i]), 64'(bp_exp[i]));
            end
        end

        // Full rate: random beats, valid and ready held high.
        begin
            int pops;
            pops      = 0;
            out_ready = 1'b1;
            for (int i = 0; i < 16; i++) begin
                in_valid = 1'b1;
                in_a     = $urandom;
                in_b     = $urandom;
                in_cin   = 1'($urandom_range(0, 1));
`ifdef ADDER_FEED_ACC_EN
                in_acc   = 1'($urandom_range(0, 1));
`endif
                check("fr_in_ready", 64'(in_ready), 64'd1);
                if (i >= 2) check("fr_out_valid", 64'(out_valid), 64'd1);
                step();
                if (got) pops++;
            end
            in_valid = 1'b0;
`ifdef ADDER_FEED_ACC_EN
            in_acc   = 1'b0;
`endif
            check("fr_pops", 64'(pops), 64'd14);
            n_seen = 0;
            drain("fr", 10);
            check("fr_tail", 64'(n_seen), 64'd2);
        end

        // Reset with two buffered results and one beat in the issue register.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = 32'(i + 1);
            in_b     = 32'd1000;
            in_cin   = 1'b0;
            step();
        end
        check("pre_rst_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        acc_model = '0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step();
        check("rst_no_stale", 64'(out_valid), 64'd0);
        in_valid = 1'b1;
        in_a     = 32'd7;
        in_b     = 32'd8;
        in_cin   = 1'b1;
        n_seen   = 0;
        drain("post_rst", 10);
        check("post_rst_count", 64'(n_seen), 64'd1);
        check("post_rst_sum", 64'(seen_sums[0]), 64'd16);

`ifdef ADDER_FEED_ACC_EN
        begin
            logic [WIDTH-1:0] acc_a   [3];
            logic             acc_sel [3];
            logic [WIDTH-1:0] acc_exp [3];
            acc_a   = '{32'd5, 32'd3, 32'd2};
            acc_sel = '{1'b0, 1'b1, 1'b1};
            acc_exp = '{32'd12, 32'd15, 32'd17};
            out_ready = 1'b1;
            n_seen    = 0;
            for (int i = 0; i < 3; i++) begin
                in_valid = 1'b1;
                in_a     = acc_a[i];
                in_b     = (i == 0) ? 32'd7 : 32'hDEAD0000;
                in_cin   = 1'b0;
                in_acc   = acc_sel[i];
                check("acc_in_ready", 64'(in_ready), 64'd1);
                step();
                if (got) begin
                    seen_sums[n_seen] = obs.sum;
                    n_seen++;
                end
            end
            in_acc = 1'b0;
            drain("acc", 10);
            check("acc_count", 64'(n_seen), 64'd3);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("acc_sum%0d", i), 64'(seen_sums[i]), 64'(acc_exp[i]));
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
